// File: rtl/uart_cmd_parser.sv
// UART command frame parser: SYNC_BYTE, CMD, ARG [, CHK] with idle timeout and error reporting.
// Define UART_CMD_CHECKSUM_EN to add the XOR checksum byte and the GET_CHK state.
module uart_cmd_parser #(
    parameter int unsigned CLK_FREQ     = 100000000,
    parameter int unsigned TIMEOUT_CLKS = 1000000,
    parameter logic [7:0]  SYNC_BYTE    = 8'hAA,
    parameter logic [7:0]  MAX_CMD      = 8'h0F
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] cmd,
    output logic [7:0] arg,
    output logic       cmd_valid,
    output logic       frame_err,
    output logic [1:0] err_code,
    output logic       busy
);
    localparam int unsigned     CntW    = $clog2(TIMEOUT_CLKS) + 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CLKS - 1);

    localparam logic [1:0] ErrTimeout = 2'b10;
    localparam logic [1:0] ErrIllegal = 2'b11;
`ifdef UART_CMD_CHECKSUM_EN
    localparam logic [1:0] ErrChecksum = 2'b01;
`endif

    if (CLK_FREQ == 0 || TIMEOUT_CLKS < 2) begin : g_param_check
        $error("uart_cmd_parser: CLK_FREQ must be nonzero and TIMEOUT_CLKS at least 2");
    end

    typedef enum logic [1:0] {
        StIdle,
        StGetCmd,
        StGetArg
`ifdef UART_CMD_CHECKSUM_EN
        , StGetChk
`endif
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [7:0]      cmd_buf_q, cmd_buf_d;
`ifdef UART_CMD_CHECKSUM_EN
    logic [7:0]      arg_buf_q, arg_buf_d;
`endif
    logic [7:0]      cmd_q, cmd_d;
    logic [7:0]      arg_q, arg_d;
    logic            cmd_valid_q, cmd_valid_d;
    logic            frame_err_q, frame_err_d;
    logic [1:0]      err_code_q, err_code_d;
    logic            done;
    logic [7:0]      done_arg;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cmd_buf_d   = cmd_buf_q;
`ifdef UART_CMD_CHECKSUM_EN
        arg_buf_d   = arg_buf_q;
`endif
        cmd_d       = cmd_q;
        arg_d       = arg_q;
        cmd_valid_d = 1'b0;
        frame_err_d = 1'b0;
        err_code_d  = err_code_q;
        done        = 1'b0;
        done_arg    = 8'h00;

        if (state_q == StIdle) begin
            cnt_d = '0;
            if (rx_valid && rx_data == SYNC_BYTE) begin
                state_d = StGetCmd;
            end
        end else if (rx_valid) begin
            // An accepted byte always beats a coincident timeout.
            cnt_d = '0;
            case (state_q)
                StGetCmd: begin
                    cmd_buf_d = rx_data;
                    state_d   = StGetArg;
                end
                StGetArg: begin
`ifdef UART_CMD_CHECKSUM_EN
                    arg_buf_d = rx_data;
                    state_d   = StGetChk;
`else
                    done      = 1'b1;
                    done_arg  = rx_data;
`endif
                end
`ifdef UART_CMD_CHECKSUM_EN
                StGetChk: begin
                    if (rx_data != (cmd_buf_q ^ arg_buf_q)) begin
                        state_d     = StIdle;
                        frame_err_d = 1'b1;
                        err_code_d  = ErrChecksum;
                    end else begin
                        done     = 1'b1;
                        done_arg = arg_buf_q;
                    end
                end
`endif
                default: state_d = StIdle;
            endcase
        end else if (cnt_q == CntLast) begin
            state_d     = StIdle;
            cnt_d       = '0;
            frame_err_d = 1'b1;
            err_code_d  = ErrTimeout;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        if (done) begin
            state_d = StIdle;
            if (cmd_buf_q > MAX_CMD) begin
                frame_err_d = 1'b1;
                err_code_d  = ErrIllegal;
            end else begin
                cmd_d       = cmd_buf_q;
                arg_d       = done_arg;
                cmd_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            cmd_buf_q   <= 8'h00;
`ifdef UART_CMD_CHECKSUM_EN
            arg_buf_q   <= 8'h00;
`endif
            cmd_q       <= 8'h00;
            arg_q       <= 8'h00;
            cmd_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            err_code_q  <= 2'b00;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmd_buf_q   <= cmd_buf_d;
`ifdef UART_CMD_CHECKSUM_EN
            arg_buf_q   <= arg_buf_d;
`endif
            cmd_q       <= cmd_d;
            arg_q       <= arg_d;
            cmd_valid_q <= cmd_valid_d;
            frame_err_q <= frame_err_d;
            err_code_q  <= err_code_d;
        end
    end

    assign cmd       = cmd_q;
    assign arg       = arg_q;
    assign cmd_valid = cmd_valid_q;
    assign frame_err = frame_err_q;
    assign err_code  = err_code_q;
    assign busy      = (state_q != StIdle);

endmodule
